// File: rtl/pcie_phy_pkg.sv
// ---------------------------------------------------------------------------
// pcie_phy_pkg
//   Definitions shared by the PHY lane blocks.
//   PHY_COM    : alignment / idle symbol that the lane transmitter sends when idle.
//   sp_state_t : state encoding of the receive-side deserializer (serial_paralelo).
// ---------------------------------------------------------------------------
package pcie_phy_pkg;

    localparam logic [7:0] PHY_COM = 8'hBC;

    typedef enum logic [1:0] {
        SP_SEARCH  = 2'd0,
        SP_LOCKING = 2'd1,
        SP_ACTIVE  = 2'd2
    } sp_state_t;

endpackage

// File: rtl/serial_paralelo.sv
// ---------------------------------------------------------------------------
// serial_paralelo
//   Receive-side deserializer of the PHY lane. It shifts in one serial bit per
//   clk_32f edge, MSB first. To find byte alignment it hunts for COM_SYMBOL.
//   It locks after LOCK_COMS consecutive aligned COMs. Once locked, it delivers
//   each non-COM byte with a single-cycle valid strobe.
//
//   Parameters
//     COM_SYMBOL    : alignment / idle symbol (default PHY_COM = 8'hBC)
//     LOCK_COMS     : aligned COMs needed to reach ACTIVE (1..15)
//     TIMEOUT_BYTES : loss-of-lock window in bytes (only with the macro below)
//
//   Ports
//     clk_32f   in  : bit clock, one serial bit per rising edge
//     reset     in  : asynchronous, active-low reset
//     data_in   in  : serial bit, MSB of each byte first
//     data_out  out : last delivered byte; holds between strobes
//     valid_out out : one-cycle strobe per delivered byte
//     active    out : high while locked (ACTIVE)
//
//   Build option
//     SERIAL_PARALELO_TIMEOUT_EN : when defined, ACTIVE falls back to SEARCH
//       after TIMEOUT_BYTES consecutive non-COM bytes. The byte that hits the
//       limit is still delivered. When undefined, ACTIVE is left only by reset.
// ---------------------------------------------------------------------------
module serial_paralelo
    import pcie_phy_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL    = PHY_COM,
    parameter int         LOCK_COMS     = 4,
    parameter int         TIMEOUT_BYTES = 16
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [3:0] LOCK_COMS_C = 4'(LOCK_COMS);

    if (LOCK_COMS < 1 || LOCK_COMS > 15 || TIMEOUT_BYTES < 1) begin : g_bad_cfg
        $error("serial_paralelo: LOCK_COMS must be 1..15 and TIMEOUT_BYTES >= 1");
    end

    // Only the seven most recent bits are kept. The eighth bit of the
    // candidate byte is the one arriving on the current edge.
    logic [6:0] sr_reg;
    logic [2:0] bit_cnt_reg;
    logic [3:0] com_cnt_reg;
    sp_state_t  state_reg;

    logic [7:0] candidate;
    logic       is_com;
    logic       boundary;

    assign candidate = {sr_reg, data_in};
    assign is_com    = (candidate == COM_SYMBOL);
    assign boundary  = (bit_cnt_reg == 3'd7);

`ifdef SERIAL_PARALELO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_BYTES + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic [TO_W-1:0] to_cnt_next;
    assign to_cnt_next = to_cnt_reg + TO_W'(1);
`endif

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
            com_cnt_reg <= '0;
            state_reg   <= SP_SEARCH;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            active      <= 1'b0;
`ifdef SERIAL_PARALELO_TIMEOUT_EN
            to_cnt_reg  <= '0;
`endif
        end else begin
            sr_reg      <= candidate[6:0];
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            valid_out   <= 1'b0;

            case (state_reg)
                // Every edge is a possible alignment point. A hit restarts the
                // bit counter, so the next boundary is 8 edges later.
                SP_SEARCH: begin
                    if (is_com) begin
                        bit_cnt_reg <= 3'd0;
                        com_cnt_reg <= 4'd1;
                        if (LOCK_COMS == 1) begin
                            state_reg <= SP_ACTIVE;
                            active    <= 1'b1;
`ifdef SERIAL_PARALELO_TIMEOUT_EN
                            to_cnt_reg <= '0;
`endif
                        end else begin
                            state_reg <= SP_LOCKING;
                        end
                    end
                end

                SP_LOCKING: begin
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt_reg <= com_cnt_reg + 4'd1;
                            if (com_cnt_reg + 4'd1 == LOCK_COMS_C) begin
                                state_reg <= SP_ACTIVE;
                                active    <= 1'b1;
`ifdef SERIAL_PARALELO_TIMEOUT_EN
                                to_cnt_reg <= '0;
`endif
                            end
                        end else begin
                            state_reg   <= SP_SEARCH;
                            com_cnt_reg <= 4'd0;
                        end
                    end
                end

                SP_ACTIVE: begin
                    if (boundary) begin
                        if (!is_com) begin
                            data_out  <= candidate;
                            valid_out <= 1'b1;
`ifdef SERIAL_PARALELO_TIMEOUT_EN
                            to_cnt_reg <= to_cnt_next;
                            if (to_cnt_next == TO_W'(TIMEOUT_BYTES)) begin
                                state_reg   <= SP_SEARCH;
                                active      <= 1'b0;
                                com_cnt_reg <= 4'd0;
                            end
`endif
                        end
`ifdef SERIAL_PARALELO_TIMEOUT_EN
                        else begin
                            to_cnt_reg <= '0;
                        end
`endif
                    end
                end

                default: begin
                    state_reg <= SP_SEARCH;
                    active    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// ---------------------------------------------------------------------------
// tb_serial_paralelo
//   Directed scenarios plus randomized byte streams for serial_paralelo.
//   After every clock edge, all outputs are compared against a stream-level
//   reference model. The model tracks the alignment anchor as a bit index
//   and does not use a bit counter.
// ---------------------------------------------------------------------------
module tb_serial_paralelo;

    localparam logic [7:0] COM           = 8'hBC;
    localparam int         LOCK_COMS     = 4;
    localparam int         TIMEOUT_BYTES = 16;

    localparam int M_SEARCH  = 0;
    localparam int M_LOCKING = 1;
    localparam int M_ACTIVE  = 2;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo #(
        .COM_SYMBOL   (COM),
        .LOCK_COMS    (LOCK_COMS),
        .TIMEOUT_BYTES(TIMEOUT_BYTES)
    ) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    // ---------------- reference model ----------------
    bit         hist[$];   // last up to 8 received bits
    int         m_mode;
    int         m_coms;
    int         m_nbits;   // bits received since reset
    int         m_anchor;  // bit index where the alignment COM ended
    int         m_run;     // consecutive non-COM bytes while locked
    logic [7:0] m_data;
    bit         m_valid;
    bit         m_active;

    // DUT observation log
    int         strobe_cyc[$];
    logic [7:0] strobe_dat[$];
    int         active_rise;
    bit         prev_active;

    task automatic model_reset();
        hist.delete();
        m_mode   = M_SEARCH;
        m_coms   = 0;
        m_nbits  = 0;
        m_anchor = 0;
        m_run    = 0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_active = 1'b0;
        strobe_cyc.delete();
        strobe_dat.delete();
        active_rise = -1;
        prev_active = 1'b0;
    endtask

    task automatic model_enter_active();
        m_mode   = M_ACTIVE;
        m_active = 1'b1;
        m_run    = 0;
    endtask

    task automatic model_edge(input bit b);
        logic [7:0] cand;
        bit         full;
        bit         on_byte;
        hist.push_back(b);
        if (hist.size() > 8) void'(hist.pop_front());
        m_nbits++;
        cand = 8'h00;
        foreach (hist[i]) cand = {cand[6:0], hist[i]};
        full    = (hist.size() == 8);
        on_byte = (((m_nbits - m_anchor) % 8) == 0);
        m_valid = 1'b0;
        case (m_mode)
            M_SEARCH: begin
                if (full && cand == COM) begin
                    m_anchor = m_nbits;
                    m_coms   = 1;
                    if (m_coms == LOCK_COMS) model_enter_active();
                    else m_mode = M_LOCKING;
                end
            end
            M_LOCKING: begin
                if (on_byte) begin
                    if (cand == COM) begin
                        m_coms++;
                        if (m_coms == LOCK_COMS) model_enter_active();
                    end else begin
                        m_mode = M_SEARCH;
                        m_coms = 0;
                    end
                end
            end
            default: begin
                if (on_byte) begin
                    if (cand != COM) begin
                        m_data  = cand;
                        m_valid = 1'b1;
                        m_run++;
`ifdef SERIAL_PARALELO_TIMEOUT_EN
                        if (m_run == TIMEOUT_BYTES) begin
                            m_mode   = M_SEARCH;
                            m_active = 1'b0;
                            m_coms   = 0;
                        end
`endif
                    end else begin
                        m_run = 0;
                    end
                end
            end
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cycle);
        end
    endtask

    task automatic tick(input bit b);
        data_in = b;
        @(posedge clk_32f);
        cycle++;
        #1;
        model_edge(b);
        check("data_out", 32'(data_out), 32'(m_data));
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("active", 32'(active), 32'(m_active));
        if (valid_out === 1'b1) begin
            strobe_cyc.push_back(cycle);
            strobe_dat.push_back(data_out);
        end
        if (active === 1'b1 && !prev_active && active_rise < 0) active_rise = cycle;
        prev_active = (active === 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(b[i]);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) tick(v[i]);
    endtask

    task automatic send_coms(input int n);
        for (int i = 0; i < n; i++) send_byte(COM);
    endtask

    // Asserts reset away from the clock edge, checks that the outputs clear at
    // once, holds reset for n edges, then releases it away from the edge.
    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        check("rst_imm_data", 32'(data_out), 32'h0);
        check("rst_imm_valid", 32'(valid_out), 32'h0);
        check("rst_imm_active", 32'(active), 32'h0);
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge clk_32f);
            cycle++;
            #1;
            check("rst_hold", 32'({data_out, valid_out, active}), 32'h0);
        end
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int mark;
        model_reset();
        #2;

        // Reset then idle COMs: lock on 4th COM, nothing delivered.
        do_reset(3);
        mark = cycle;
        send_coms(6);
        check("idle_lock_edge", 32'(active_rise - mark), 32'(8 * LOCK_COMS));
        check("idle_no_strobe", 32'(strobe_dat.size()), 32'd0);
        check("idle_data_zero", 32'(data_out), 32'h0);

        // Misaligned start.
        do_reset(2);
        send_bits(8'b101, 3);
        send_coms(4);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(COM);
        check("mis_count", 32'(strobe_dat.size()), 32'd2);
        check("mis_byte0", 32'(strobe_dat[0]), 32'hA5);
        check("mis_byte1", 32'(strobe_dat[1]), 32'h3C);
        check("mis_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd8);
        check("mis_first_lat", 32'(strobe_cyc[0] - active_rise), 32'd8);

        // Broken lock.
        do_reset(2);
        send_coms(2);
        send_byte(8'h11);
        check("brk_unlocked", 32'(active), 32'h0);
        send_coms(4);
        send_byte(8'h55);
        send_byte(COM);
        check("brk_count", 32'(strobe_dat.size()), 32'd1);
        check("brk_byte", 32'(strobe_dat[0]), 32'h55);

        // Reset mid-byte.
        do_reset(2);
        send_coms(4);
        send_bits(8'hF, 4);
        do_reset(2);
        send_bits(8'h0, 4);
        send_byte(8'hF0);
        check("midrst_none", 32'(strobe_dat.size()), 32'd0);
        send_coms(4);
        send_byte(8'hF0);
        check("midrst_relock", 32'(strobe_dat.size()), 32'd1);
        check("midrst_byte", 32'(strobe_dat[0]), 32'hF0);

        // Interleaved idle.
        do_reset(2);
        send_coms(4);
        send_byte(8'h01);
        send_bits(COM[7:4], 4);
        check("ilv_hold", 32'(data_out), 32'h01);
        send_bits(COM[3:0], 4);
        send_byte(8'h02);
        send_byte(COM);
        check("ilv_count", 32'(strobe_dat.size()), 32'd2);
        check("ilv_byte0", 32'(strobe_dat[0]), 32'h01);
        check("ilv_byte1", 32'(strobe_dat[1]), 32'h02);
        check("ilv_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd16);

        // Long run of non-COM bytes: locked behaviour depends on build option.
        do_reset(2);
        send_coms(4);
        for (int i = 0; i < TIMEOUT_BYTES + 2; i++) send_byte(8'(i + 1));
        check("run_count", 32'(strobe_dat.size()),
`ifdef SERIAL_PARALELO_TIMEOUT_EN
              32'(TIMEOUT_BYTES));
`else
              32'(TIMEOUT_BYTES + 2));
`endif

        // Randomized streams: junk before lock, then mixed bytes and slips.
        for (int run = 0; run < 4; run++) begin
            do_reset(1 + run);
            for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
            send_coms(4);
            for (int i = 0; i < 40; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0) send_bits(8'($urandom_range(0, 255)), $urandom_range(1, 7));
                else if (r < 4) send_byte(COM);
                else send_byte(8'($urandom_range(0, 255)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_paralelo.md
# serial_paralelo

Receive-side deserializer of the PHY lane: samples the serial bit stream MSB-first on `clk_32f` and finds byte alignment by hunting for the COM symbol `8'hBC`. It locks after a configurable run of consecutive COMs, then delivers each non-COM byte on an 8-bit bus with a one-cycle valid strobe. It is the receive-side counterpart of the lane's parallel-to-serial transmitter, which sends `8'hBC` when idle.

## Interface
- `COM_SYMBOL`, default `8'hBC`: alignment/idle symbol.
- `LOCK_COMS`, default 4: consecutive aligned COMs required to reach ACTIVE (range 1..15).
- `TIMEOUT_BYTES`, default 16: byte window for loss-of-lock detection (used only with the macro).
- `clk_32f` input 1: bit clock; one serial bit per rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `data_in` input 1: serial bit, MSB of each byte first.
- `data_out` output 8: last delivered byte; holds between strobes.
- `valid_out` output 1: high for exactly one cycle per delivered byte.
- `active` output 1: high while in ACTIVE.

## Operation
- Shift register `sr[7:0]`, loaded as `sr <= {sr[6:0], data_in}` every edge, in every state except reset.
- The candidate byte is `{sr[6:0], data_in}`, i.e. the byte completed by the current edge.
- Bit counter `bit_cnt[2:0]`: a byte boundary occurs on an edge where `bit_cnt == 7`.
- States:
  - SEARCH:
    - Entered from reset.
    - On any edge where the candidate equals COM: `bit_cnt <= 0`, `com_cnt <= 1`, go to LOCKING. If `LOCK_COMS == 1`, go directly to ACTIVE.
    - On all other edges, `bit_cnt` is ignored.
  - LOCKING:
    - Evaluated at byte boundaries only.
    - Candidate == COM: increment `com_cnt`; when the count reaches `LOCK_COMS`, go to ACTIVE.
    - Any other byte: return to SEARCH and clear `com_cnt`.
    - No bytes are delivered in this state.
  - ACTIVE:
    - Evaluated at byte boundaries.
    - Candidate != COM: `data_out <=` candidate, `valid_out <= 1`.
    - Candidate == COM: idle; `valid_out <= 0`, `data_out` unchanged.
    - With the macro off, ACTIVE is left only by reset.
- `valid_out` is cleared on every edge that is not an ACTIVE byte boundary with a non-COM candidate.
- A COM arriving at a misaligned bit position while in LOCKING or ACTIVE is ignored. Re-alignment happens only through SEARCH.

## Timing
- Reset (`reset == 0`, asynchronous):
  - State goes to SEARCH.
  - `sr`, `bit_cnt` and `com_cnt` clear to 0.
  - `data_out = 8'h00`, `valid_out = 0`, `active = 0`.
  - Applies mid-byte and mid-lock; no partial byte is ever delivered.
- Latency: the LSB of a byte is sampled on edge k, and `data_out`/`valid_out` are valid in the cycle after edge k. Serial-in to parallel-out latency is 1 cycle after the last bit.
- Byte rate: `valid_out` pulses at most once every 8 cycles.
- Lock:
  - The first COM is detected on its LSB edge.
  - `active` rises on the LSB edge of COM number `LOCK_COMS`.
  - With no slips, the first payload byte's strobe occurs 8 cycles after `active` rises, or later.
- `active` is registered and changes on the same edge as the state transition.

## Configuration
- `SERIAL_PARALELO_TIMEOUT_EN` defined:
  - In ACTIVE, a byte counter `to_cnt` resets on every COM byte and increments on every non-COM byte.
  - When `to_cnt` reaches `TIMEOUT_BYTES`, return to SEARCH with `active <= 0`. The byte that hits the limit is still delivered.
  - `to_cnt` clears on reset and on entry to ACTIVE.
- Macro undefined: no timeout logic is synthesized, and ACTIVE is sticky until reset.

## Structure
- Shared package `pcie_phy_pkg` holds:
  - constant `PHY_COM = 8'hBC`, used as the default for `COM_SYMBOL`;
  - the state enum `{SP_SEARCH, SP_LOCKING, SP_ACTIVE}`, encoded in 2 bits.
- Single module; no sub-module. The shift register, counters and FSM are kept together.

## Test plan
- Reset then idle: hold `reset = 0` for 3 cycles and release, then send continuous `8'hBC`. Required: `active` rises on the LSB edge of the 4th COM, `valid_out` never asserts, and `data_out` stays `8'h00`.
- Misaligned start: send 3 junk bits `101`, then COM ×4, then `8'hA5`, `8'h3C`. Required: lock is achieved despite the junk bits; `data_out` shows `8'hA5` then `8'h3C`, each with a single-cycle `valid_out` exactly 8 cycles apart.
- Broken lock: send COM ×2, then `8'h11`, then COM ×4, then `8'h55`. Required: the FSM returns to SEARCH after `8'h11`, `8'h11` is not delivered, and only `8'h55` is delivered after relock.
- Reset mid-byte: while ACTIVE, pull `reset` low after 4 bits of `8'hF0`. Required: all outputs go to 0 immediately, and after release `8'hF0` is not delivered until relock.
- Interleaved idle: while ACTIVE, send `8'h01`, COM, `8'h02`. Required: two strobes, 16 cycles apart; `data_out` holds `8'h01` during the COM byte.
- With `SERIAL_PARALELO_TIMEOUT_EN` and `TIMEOUT_BYTES = 16`: while ACTIVE, send 16 non-COM bytes. Required: all 16 are delivered, and `active` falls on the LSB edge of the 16th byte.
